fpu_mul_seq: RTL and testbench

FPU_MUL_SEQ -- requirements
Module: fpu_mul_seq

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_classify.sv | 19 +
 rtl/fpu_mul_seq.sv | 178 +++++++++++++++++
 tb/tb_fpu_mul_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared IEEE754 single-precision constants and FSM state type for the FPU blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int FP_W     = SIGN_W + EXP_W + MANT_W;
    localparam int SIG_W    = MANT_W + 1;
    localparam int PROD_W   = 2 * SIG_W;
    localparam int ESUM_W   = EXP_W + 2;
    localparam int EXP_BIAS = 127;

    localparam logic [FP_W-1:0]  QNAN      = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [4:0]       LAST_ITER = 5'(SIG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;
endpackage

// File: rtl/fpu_classify.sv
// Decodes one single-precision operand into zero / inf / NaN flags.
// Latency: combinational.
// Backpressure: none.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_f,
    input  logic [MANT_W-1:0] mant_f,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);
    // Denormals count as zero: the mantissa is ignored when the exponent is 0.
    always_comb begin
        is_zero = (exp_f == '0);
        is_inf  = (exp_f == EXP_MAX) && (mant_f == '0);
        is_nan  = (exp_f == EXP_MAX) && (mant_f != '0);
    end
endmodule

// File: rtl/fpu_mul_seq.sv
// Sequential single-precision multiplier: radix-2 shift-add, truncating, denormals flushed.
// Latency: 25 cycles from accept to done (normal), 1 cycle for special operands.
// Backpressure: en ignored while busy; next request accepted the cycle after DONE.
module fpu_mul_seq
    import fpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [FP_W-1:0] result
);
    localparam logic signed [ESUM_W-1:0] BIAS_S  = ESUM_W'(EXP_BIAS);
    localparam logic signed [ESUM_W-1:0] ONE_S   = ESUM_W'(1);
    localparam logic signed [ESUM_W-1:0] ZERO_S  = '0;
    localparam logic signed [ESUM_W-1:0] EXP_OVF = ESUM_W'(255);

    state_t                   state_q, state_d;
    logic [PROD_W-1:0]        mcand_q, mcand_d;
    logic [PROD_W-1:0]        acc_q, acc_d;
    logic [SIG_W-1:0]         mplr_q, mplr_d;
    logic [4:0]               cnt_q, cnt_d;
    logic signed [ESUM_W-1:0] exp_q, exp_d;
    logic                     sign_q, sign_d;
    logic                     special_q, special_d;
    logic                     done_q, done_d;
    logic [FP_W-1:0]          spec_q, spec_d;
    logic [FP_W-1:0]          result_q, result_d;

    logic                     a_zero, a_inf, a_nan;
    logic                     b_zero, b_inf, b_nan;
    logic                     sign_in, is_special;
    logic [FP_W-1:0]          spec_val;
    logic signed [ESUM_W-1:0] exp_in, exp_norm;
    logic [MANT_W-1:0]        mant_norm;
    logic [FP_W-1:0]          norm_val;

    fpu_classify u_cls_a (
        .exp_f  (A[FP_W-2 -: EXP_W]),
        .mant_f (A[MANT_W-1:0]),
        .is_zero(a_zero),
        .is_inf (a_inf),
        .is_nan (a_nan)
    );

    fpu_classify u_cls_b (
        .exp_f  (B[FP_W-2 -: EXP_W]),
        .mant_f (B[MANT_W-1:0]),
        .is_zero(b_zero),
        .is_inf (b_inf),
        .is_nan (b_nan)
    );

    // Operand decode used only on the accept edge.
    always_comb begin
        sign_in    = A[FP_W-1] ^ B[FP_W-1];
        is_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_val = QNAN;
        end else if (a_zero || b_zero) begin
            spec_val = '0;
        end else begin
            spec_val = {sign_in, EXP_MAX, {MANT_W{1'b0}}};
        end
        exp_in = $signed({2'b00, A[FP_W-2 -: EXP_W]}) + $signed({2'b00, B[FP_W-2 -: EXP_W]}) - BIAS_S;
    end

    // Product lies in [1,4): bit 47 set means one extra exponent step.
    always_comb begin
        if (acc_q[PROD_W-1]) begin
            exp_norm  = exp_q + ONE_S;
            mant_norm = acc_q[PROD_W-2 -: MANT_W];
        end else begin
            exp_norm  = exp_q;
            mant_norm = acc_q[PROD_W-3 -: MANT_W];
        end
        if (exp_norm >= EXP_OVF) begin
            norm_val = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
        end else if (exp_norm <= ZERO_S) begin
            norm_val = '0;
        end else begin
            norm_val = {sign_q, exp_norm[EXP_W-1:0], mant_norm};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = is_special ? NORM : MUL;
            MUL:     if (cnt_q == LAST_ITER) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        special_d = special_q;
        spec_d    = spec_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    mcand_d   = {{SIG_W{1'b0}}, 1'b1, A[MANT_W-1:0]};
                    mplr_d    = {1'b1, B[MANT_W-1:0]};
                    acc_d     = '0;
                    cnt_d     = '0;
                    exp_d     = exp_in;
                    sign_d    = sign_in;
                    special_d = is_special;
                    spec_d    = spec_val;
                end
            end
            MUL: begin
                // One multiplier bit per cycle, LSB first.
                if (mplr_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 5'd1;
            end
            NORM: begin
                result_d = special_q ? spec_q : norm_val;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            special_q <= special_d;
            spec_q    <= spec_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = done_q;
        result = result_q;
    end
endmodule

// File: tb/tb_fpu_mul_seq.sv
// Testbench for fpu_mul_seq: directed and randomized products against a behavioural model.
module tb_fpu_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    // Reference product from the IEEE field rules with plain integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        bit          s, az, bz, ai, bi, an, bn;
        logic [47:0] ma, mb, p;
        logic [22:0] m;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        if (an || bn || (ai && bz) || (az && bi)) return 32'h7FC00000;
        if (az || bz) return 32'h0;
        if (ai || bi) return {s, 8'hFF, 23'h0};
        ma = {24'h0, 1'b1, a[22:0]};
        mb = {24'h0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= 48'h8000_0000_0000) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          c;
        v = $urandom;
        c = $urandom_range(0, 9);
        if (c == 0) begin
            v[30:23] = 8'h00;
        end else if (c == 1) begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) v[22:0] = '0;
        end else if (c == 2) begin
            v[30:23] = 8'($urandom_range(190, 254));
        end else if (c == 3) begin
            v[30:23] = 8'($urandom_range(1, 64));
        end else begin
            v[30:23] = 8'($urandom_range(100, 154));
        end
        return v;
    endfunction

    // Issues one request from idle, scrambles operands afterwards, observes until idle again.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int busy_n, output int done_n);
        A  = a;
        B  = b;
        en = 1'b1;
        @(posedge clk);
        #1;
        en     = 1'b0;
        A      = $urandom;
        B      = $urandom;
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        res    = 32'hDEAD_BEEF;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                A = $urandom;
                B = $urandom;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[7]  = '{32'h40400000, 32'h3FC00000, 32'hC0000000, 32'h7F800000, 32'h00400000, 32'h7F000000, 32'h00800000};
        logic [31:0] vb[7]  = '{32'h40000000, 32'h3FC00000, 32'h3F000000, 32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000};
        logic [31:0] vr[7]  = '{32'h40C00000, 32'h40100000, 32'hBF800000, 32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000};
        int          vl[7]  = '{25, 25, 25, 1, 1, 25, 25};
        int          vbz[7] = '{26, 26, 26, 2, 2, 26, 26};
        logic [31:0] res;
        int          lat, bn, dn;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], res, lat, bn, dn);
            n_tests++;
            if (res !== vr[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, vr[i]);
            end
            n_tests++;
            if (lat != vl[i] || dn != 1) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: latency %0d pulses %0d, want %0d and 1", i, lat, dn, vl[i]);
            end
            n_tests++;
            if (bn != vbz[i]) begin
                n_fail++;
                $display("FAIL directed_busy[%0d]: busy cycles %0d want %0d", i, bn, vbz[i]);
            end
            n_tests++;
            if (result !== vr[i]) begin
                n_fail++;
                $display("FAIL directed_hold[%0d]: got %h want %h", i, result, vr[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_r;
        int          lat, bn, dn, exp_l;
        for (int i = 0; i < 60; i++) begin
            a     = rand_op();
            b     = rand_op();
            exp_r = ref_mul(a, b);
            exp_l = is_special(a, b) ? 1 : 25;
            run_op(a, b, res, lat, bn, dn);
            n_tests++;
            if (res !== exp_r) begin
                n_fail++;
                $display("FAIL random_result[%0d]: %h*%h got %h want %h", i, a, b, res, exp_r);
            end
            n_tests++;
            if (lat != exp_l || dn != 1) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: latency %0d pulses %0d, want %0d and 1", i, lat, dn, exp_l);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          d1, d2;
        logic [31:0] r1, r2;
        logic        b26, b27;
        d1  = -1;
        d2  = -1;
        r1  = '0;
        r2  = '0;
        b26 = 1'bx;
        b27 = 1'bx;
        A   = 32'h40400000;
        B   = 32'h40000000;
        en  = 1'b1;
        @(posedge clk);
        #1;
        A = 32'h3FC00000;
        B = 32'h3FC00000;
        for (int k = 1; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (k == 26) b26 = busy;
            if (k == 27) begin
                b27 = busy;
                en  = 1'b0;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    r1 = result;
                end else if (d2 < 0) begin
                    d2 = k;
                    r2 = result;
                end
            end
        end
        n_tests++;
        if (d1 != 25 || r1 !== 32'h40C00000) begin
            n_fail++;
            $display("FAIL b2b_first: done at %0d result %h, want 25 40c00000", d1, r1);
        end
        n_tests++;
        if (b26 !== 1'b0 || b27 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: busy after edge 26/27 = %b/%b, want 0/1", b26, b27);
        end
        n_tests++;
        if (d2 != 52 || r2 !== 32'h40100000) begin
            n_fail++;
            $display("FAIL b2b_second: done at %0d result %h, want 52 40100000", d2, r2);
        end
    endtask

    task automatic test_abort();
        bit          saw_done;
        int          stray;
        logic [31:0] res;
        int          lat, bn, dn;
        saw_done = 1'b0;
        stray    = 0;
        A  = 32'h40400000;
        B  = 32'h40000000;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
            if (k == 9) begin
                en = 1'b1;
                A  = 32'h3FC00000;
                B  = 32'h3FC00000;
            end
            if (k == 10) en = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        n_tests++;
        if (saw_done || stray != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: early done %0d, busy/done cycles after reset %0d, want 0 and 0", saw_done, stray);
        end
        n_tests++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_result: got %h want 00000000", result);
        end
        run_op(32'h40400000, 32'h40000000, res, lat, bn, dn);
        n_tests++;
        if (res !== 32'h40C00000 || lat != 25 || dn != 1) begin
            n_fail++;
            $display("FAIL abort_fresh: result %h latency %0d pulses %0d, want 40c00000 25 1", res, lat, dn);
        end
    endtask

    task automatic test_hold();
        int          stray;
        logic [31:0] held;
        held  = ref_mul(32'h40400000, 32'h40000000);
        stray = 0;
        en    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            A = $urandom;
            B = $urandom;
            @(posedge clk);
            #1;
            if (done || busy || result !== held) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL idle_hold: %0d disturbed cycles, result %h want %h", stray, result, held);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
